// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its busy scoreboard.
// Data vectors are declared [0:DATA_WIDTH-1], so bit 0 is the MSB.
package regfile_pkg;
  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;
endpackage

// File: rtl/busy_table.sv
// Per-register busy bits for RAW hazard detection, plus the drain flag.
module busy_table
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       writeEnable,
  input  logic [ADDR_WIDTH-1:0]      rd,
  input  logic                       resvEnable,
  input  logic [ADDR_WIDTH-1:0]      resvReg,
  output logic [2**ADDR_WIDTH-1:0]   busy,
  output logic                       anyBusy
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  for (genvar r = 0; r < DEPTH; r++) begin : g_busy
    if (ZERO_REG != 0 && r == REG_ZERO) begin : g_zero
      assign busy[r] = 1'b0;
    end else begin : g_bit
      logic set_r, clr_r;
      assign set_r = resvEnable  && (resvReg == ADDR_WIDTH'(r));
      assign clr_r = writeEnable && (rd      == ADDR_WIDTH'(r));
      // A newer producer issuing on the same edge outranks the completing one.
      always_ff @(posedge clk) begin
        if (reset)      busy[r] <= 1'b0;
        else if (set_r) busy[r] <= 1'b1;
        else if (clr_r) busy[r] <= 1'b0;
      end
    end
  end

  assign anyBusy = |busy;
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional zero register, writeback
// bypass, and a busy scoreboard for the issue stage.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [0:DATA_WIDTH-1] busW,
  input  logic                  writeEnable,
  input  logic                  resvEnable,
  input  logic [ADDR_WIDTH-1:0] resvReg,
  output logic [0:DATA_WIDTH-1] busA,
  output logic [0:DATA_WIDTH-1] busB,
  output logic                  busyA,
  output logic                  busyB,
  output logic                  anyBusy
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][0:DATA_WIDTH-1] regs;
  logic [DEPTH-1:0]                 busy;

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    if (ZERO_REG != 0 && r == REG_ZERO) begin : g_zero
      assign regs[r] = '0;
    end else begin : g_flop
      logic wr_en;
      assign wr_en = writeEnable && (rd == ADDR_WIDTH'(r));
      always_ff @(posedge clk) begin
        if (reset)      regs[r] <= '0;
        else if (wr_en) regs[r] <= busW;
      end
    end
  end

  busy_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_busy (
    .clk         (clk),
    .reset       (reset),
    .writeEnable (writeEnable),
    .rd          (rd),
    .resvEnable  (resvEnable),
    .resvReg     (resvReg),
    .busy        (busy),
    .anyBusy     (anyBusy)
  );

  logic fwd_a, fwd_b, zero_a, zero_b;
  assign fwd_a  = (BYPASS != 0) && writeEnable && (rd == rs);
  assign fwd_b  = (BYPASS != 0) && writeEnable && (rd == rt);
  assign zero_a = (ZERO_REG != 0) && (rs == ADDR_WIDTH'(REG_ZERO));
  assign zero_b = (ZERO_REG != 0) && (rt == ADDR_WIDTH'(REG_ZERO));

  // Zero register wins over forwarding: its write is dropped, so nothing to forward.
  always_comb begin
    busA = regs[rs];
    busB = regs[rt];
    if (fwd_a)  busA = busW;
    if (fwd_b)  busB = busW;
    if (zero_a) busA = '0;
    if (zero_b) busB = '0;
  end

  // A producer completing this cycle is forwarded, so it is not a hazard.
  assign busyA = busy[rs] && !fwd_a;
  assign busyB = busy[rt] && !fwd_b;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed check of regfile_scoreboard in two configurations
// against an array-based behavioural model.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset, writeEnable, resvEnable;
  logic [4:0]  rs, rt, rd, resvReg;
  logic [31:0] busW;

  logic [31:0] busA_a, busB_a, busA_b, busB_b;
  logic        busyA_a, busyB_a, anyBusy_a, busyA_b, busyB_b, anyBusy_b;

  int tests = 0;
  int fails = 0;

  // model: index 0 = ZERO_REG=1/BYPASS=1, index 1 = ZERO_REG=0/BYPASS=0
  logic [31:0] mreg  [2][32];
  bit          mbusy [2][32];

  always #5 clk = ~clk;

  regfile_scoreboard u_a (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .busW(busW),
    .writeEnable(writeEnable), .resvEnable(resvEnable), .resvReg(resvReg),
    .busA(busA_a), .busB(busB_a), .busyA(busyA_a), .busyB(busyB_a), .anyBusy(anyBusy_a)
  );

  regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd(rd), .busW(busW),
    .writeEnable(writeEnable), .resvEnable(resvEnable), .resvReg(resvReg),
    .busA(busA_b), .busB(busB_b), .busyA(busyA_b), .busyB(busyB_b), .anyBusy(anyBusy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] m_bus(input int c, input logic [4:0] a);
    if (c == 0 && a == 5'd0) return 32'h0;
    if (c == 0 && writeEnable && rd == a) return busW;
    return mreg[c][a];
  endfunction

  function automatic logic m_busy(input int c, input logic [4:0] a);
    if (c == 0) return mbusy[c][a] && !(writeEnable && rd == a);
    return mbusy[c][a];
  endfunction

  function automatic logic m_any(input int c);
    logic any = 1'b0;
    for (int i = 0; i < 32; i++) any |= mbusy[c][i];
    return any;
  endfunction

  task automatic compare_all();
    chk("busA_a",    busA_a,          m_bus(0, rs));
    chk("busB_a",    busB_a,          m_bus(0, rt));
    chk("busyA_a",   32'(busyA_a),    32'(m_busy(0, rs)));
    chk("busyB_a",   32'(busyB_a),    32'(m_busy(0, rt)));
    chk("anyBusy_a", 32'(anyBusy_a),  32'(m_any(0)));
    chk("busA_b",    busA_b,          m_bus(1, rs));
    chk("busB_b",    busB_b,          m_bus(1, rt));
    chk("busyA_b",   32'(busyA_b),    32'(m_busy(1, rs)));
    chk("busyB_b",   32'(busyB_b),    32'(m_busy(1, rt)));
    chk("anyBusy_b", 32'(anyBusy_b),  32'(m_any(1)));
  endtask

  // Apply the edge's effect to the model using the inputs held this cycle.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) begin
          mreg[c][i]  = 32'h0;
          mbusy[c][i] = 1'b0;
        end
      end else begin
        if (writeEnable && !(c == 0 && rd == 5'd0)) mreg[c][rd] = busW;
        if (writeEnable) mbusy[c][rd] = 1'b0;
        if (resvEnable && !(c == 0 && resvReg == 5'd0)) mbusy[c][resvReg] = 1'b1;
      end
    end
  endtask

  // Called just after a rising edge; returns at the following falling edge.
  task automatic drive(input logic rst, input logic we, input logic [4:0] d,
                       input logic [31:0] w, input logic rv, input logic [4:0] rr,
                       input logic [4:0] a, input logic [4:0] b, input bit cmp);
    reset = rst; writeEnable = we; rd = d; busW = w;
    resvEnable = rv; resvReg = rr; rs = a; rt = b;
    @(negedge clk);
    if (cmp) compare_all();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; writeEnable = 1'b0; resvEnable = 1'b0;
    rs = '0; rt = '0; rd = '0; resvReg = '0; busW = '0;
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); advance();

    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 1);
      chk("rst_busA", busA_a, 32'h0);
      chk("rst_busB", busB_b, 32'h0);
      chk("rst_any",  32'(anyBusy_a | anyBusy_b), 32'h0);
      advance();
    end

    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 1);
    chk("byp_same_cycle", busA_a, 32'hDEADBEEF);
    chk("nobyp_old",      busA_b, 32'h0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 5, 0, 1);
    chk("byp_next", busA_a, 32'hDEADBEEF);
    chk("nobyp_next", busA_b, 32'hDEADBEEF);
    advance();

    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    chk("zero_write_byp", busA_a, 32'h0);
    advance();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 1);
    chk("zero_read", busA_a, 32'h0);
    chk("r0_normal", busA_b, 32'hFFFFFFFF);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("zero_busy", 32'(busyA_a), 32'h0);
    chk("zero_any",  32'(anyBusy_a), 32'h0);
    advance();

    drive(0, 0, 0, 0, 1, 7, 7, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 7, 0, 1);
    chk("resv_busyA", 32'(busyA_a), 32'h1);
    chk("resv_any",   32'(anyBusy_a), 32'h1);
    advance();
    drive(0, 1, 7, 32'h12, 0, 0, 7, 0, 1);
    chk("wb_busyA", 32'(busyA_a), 32'h0);
    chk("wb_busA",  busA_a, 32'h12);
    chk("wb_busyA_nobyp", 32'(busyA_b), 32'h1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 7, 0, 1);
    chk("wb_after_busy", 32'(busyA_a), 32'h0);
    chk("wb_after_any",  32'(anyBusy_a), 32'h0);
    advance();

    drive(0, 1, 9, 32'h55, 1, 9, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 9, 9, 1);
    chk("resv_beats_wr_data", busA_a, 32'h55);
    chk("resv_beats_wr_busy", 32'(busyA_a), 32'h1);
    advance();

    drive(0, 0, 0, 0, 1, 3, 0, 0, 1); advance();
    drive(0, 1, 4, 32'hA5, 0, 0, 0, 0, 1); advance();
    drive(0, 1, 3, 32'h33, 0, 0, 0, 0, 1); advance();
    drive(1, 1, 4, 32'h77, 0, 0, 0, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 3, 4, 1);
    chk("rst_mid_r3",  busA_a, 32'h0);
    chk("rst_mid_r4",  busB_a, 32'h0);
    chk("rst_mid_any", 32'(anyBusy_a | anyBusy_b), 32'h0);
    advance();

    for (int n = 0; n < 3000; n++) begin
      logic       r_rst, r_we, r_rv;
      logic [4:0] r_d, r_rr, r_a, r_b;
      r_rst = ($urandom_range(0, 63) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_rv  = ($urandom_range(0, 2) == 0);
      r_d   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      r_rr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      r_a   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      r_b   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      drive(r_rst, r_we, r_d, $urandom, r_rv, r_rr, r_a, r_b, 1);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
